esdi_read_sequencer: RTL and testbench
======================================

# esdi_read_sequencer

Sequences ESDI sector reads: after a command is accepted, it waits for each drive sector pulse and drives `esdi_read_gate` with a header window and then a data window. It also drives the `gate_for_header` and `gate_for_data` qualifiers consumed by the read datapath. It sits between the host command/CSR logic and the read datapath/drive interface. It repeats the header/data sequence for a commanded number of consecutive sectors and reports done or error.

## Interface
Parameters:
- CNT_WIDTH, 16, width of all window/delay counters and cfg inputs.
- TIMEOUT_CYCLES, 1000000, maximum cycles to wait for a sector pulse (used only with the timeout feature).

Ports:
- sector_aclk  in  1  block clock; all logic on rising edge.
- sector_areset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_sector_count  in  8  sectors to read; 0 means 256.
- cfg_header_delay  in  CNT_WIDTH  cycles from sector pulse edge to header gate.
- cfg_header_len  in  CNT_WIDTH  header gate-high cycles; 0 treated as 1.
- cfg_gap_len  in  CNT_WIDTH  gate-low cycles between header and data windows.
- cfg_data_len  in  CNT_WIDTH  data gate-high cycles; 0 treated as 1.
- esdi_sector  in  1  drive sector pulse, already synchronized to sector_aclk.
- abort  in  1  synchronous abort request.
- esdi_read_gate  out  1  read gate to drive and datapath.
- gate_for_header  out  1  high during header window.
- gate_for_data  out  1  high during data window.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on normal completion.
- error  out  1  sticky; cleared on next command accept.
- sectors_remaining  out  9  sectors not yet completed.

## Operation
- All outputs are registered. Reset value of every output is 0, except cmd_ready = 1. The state machine resets to IDLE.
- Config inputs are captured into internal registers on command accept. Changes made mid-command are ignored.
- Sector edge: `sec_edge = esdi_sector & ~esdi_sector_q`. `esdi_sector_q` resets to 0.
- States and transitions:
  - IDLE: on cmd_valid, accept the command; load sectors_remaining with count (0 -> 256); clear error; go to WAIT_SECTOR.
  - WAIT_SECTOR: on sec_edge, go to HDR_DELAY; if captured delay = 0, go directly to HDR_GATE.
  - HDR_DELAY: count captured delay cycles, then go to HDR_GATE.
  - HDR_GATE: esdi_read_gate = gate_for_header = 1 for max(len,1) cycles; then go to GAP, or to DATA_GATE if gap = 0.
  - GAP: all gates 0 for gap cycles; then go to DATA_GATE.
  - DATA_GATE: esdi_read_gate = gate_for_data = 1 for max(len,1) cycles; then go to NEXT.
  - NEXT (1 cycle): decrement sectors_remaining. If the result is 0, pulse done and go to IDLE; else go to WAIT_SECTOR.
- gate_for_header and gate_for_data are never high simultaneously. esdi_read_gate equals their OR.
- sec_edge seen in HDR_DELAY, HDR_GATE, GAP or DATA_GATE is an overrun:
  - set error, drop all gates, go to IDLE; no done pulse.
  - sectors_remaining holds its value.
- sec_edge in NEXT is not lost: the next WAIT_SECTOR starts as if the edge occurred then.
- abort in any non-IDLE state: gates drop next cycle, go to IDLE, no done, no error. abort in IDLE is ignored.
- Overrun and abort in the same cycle: abort wins, so error is not set.
- Counter arithmetic is unsigned CNT_WIDTH bits and never wraps; each counter reloads on state entry.

## Timing
- Command accepted at cycle c (cmd_valid & cmd_ready): cmd_ready = 0 and busy = 1 from c+1.
- sec_edge sampled at cycle t, delay D, header length H, gap G, data length L:
  - esdi_read_gate high cycles t+1+D through t+D+H.
  - Data gate high from t+1+D+H+G for L cycles.
  - NEXT occupies the cycle after the last data cycle; done is asserted in the cycle after NEXT, together with busy = 0 and cmd_ready = 1.
- Reset asserted mid-operation: all gates drop immediately (asynchronous). State returns to IDLE.

## Configuration
- Macro `ESDI_READ_SEQ_TIMEOUT_EN`.
- Defined: a counter runs in WAIT_SECTOR and resets on state entry. After TIMEOUT_CYCLES cycles without sec_edge, error is set and the block returns to IDLE without a done pulse.
- Undefined: no timeout counter is built; WAIT_SECTOR waits indefinitely and only abort or reset exits it.

## Test plan
- Count = 1, D = 3, H = 4, G = 2, L = 8, sector pulse at t -> read gate high t+4..t+7 with gate_for_header, low t+8..t+9, high t+10..t+17 with gate_for_data, done at t+19.
- Count = 3, sector pulses every 100 cycles -> three identical gate sequences, sectors_remaining 3 -> 2 -> 1 -> 0, a single done, error = 0.
- Sector pulse during DATA_GATE -> gates 0 next cycle, error = 1, no done, sectors_remaining unchanged. The next command accept clears error.
- abort asserted in GAP -> gates 0, busy 0 next cycle, error = 0, no done. abort and overrun in the same cycle -> error = 0.
- Lengths H = 0, L = 0, G = 0, D = 0 -> header gate 1 cycle at t+1, data gate 1 cycle at t+2. Count = 0 -> 256 sectors completed.
- With `ESDI_READ_SEQ_TIMEOUT_EN` and TIMEOUT_CYCLES = 50, no pulse -> error = 1 and IDLE after 50 cycles in WAIT_SECTOR. Without the macro, still busy after 10000 cycles.

Source files
------------

// File: rtl/esdi_read_sequencer_if.sv
// Command, config, drive and status signals of the ESDI read sequencer.
// slave = sequencer side, master = host/drive side.
interface esdi_read_sequencer_if #(
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [7:0]           cmd_sector_count;
  logic [CNT_WIDTH-1:0] cfg_header_delay;
  logic [CNT_WIDTH-1:0] cfg_header_len;
  logic [CNT_WIDTH-1:0] cfg_gap_len;
  logic [CNT_WIDTH-1:0] cfg_data_len;
  logic                 esdi_sector;
  logic                 abort;
  logic                 esdi_read_gate;
  logic                 gate_for_header;
  logic                 gate_for_data;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [8:0]           sectors_remaining;

  modport master (
    output cmd_valid, cmd_sector_count, cfg_header_delay, cfg_header_len,
           cfg_gap_len, cfg_data_len, esdi_sector, abort,
    input  cmd_ready, esdi_read_gate, gate_for_header, gate_for_data,
           busy, done, error, sectors_remaining
  );

  modport slave (
    input  cmd_valid, cmd_sector_count, cfg_header_delay, cfg_header_len,
           cfg_gap_len, cfg_data_len, esdi_sector, abort,
    output cmd_ready, esdi_read_gate, gate_for_header, gate_for_data,
           busy, done, error, sectors_remaining
  );
endinterface

// File: rtl/esdi_read_sequencer.sv
// ESDI sector read sequencer: per sector pulse, opens a header then a data read-gate window.
// Optional WAIT_SECTOR timeout is built only when ESDI_READ_SEQ_TIMEOUT_EN is defined.
module esdi_read_sequencer #(
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input logic                  sector_aclk,
  input logic                  sector_areset,
  esdi_read_sequencer_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SECTOR, S_HDR_DELAY, S_HDR_GATE, S_GAP, S_DATA_GATE, S_NEXT
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cap_delay;
  logic [CNT_WIDTH-1:0] cap_hdr_len;
  logic [CNT_WIDTH-1:0] cap_gap_len;
  logic [CNT_WIDTH-1:0] cap_data_len;
  logic                 sector_q;
  logic                 edge_pend;
  logic                 cmd_ready_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 error_r;
  logic                 hdr_r;
  logic                 data_r;
  logic                 gate_r;
  logic [8:0]           remaining_r;
  logic                 sec_edge;
  logic                 tmo_hit;

  assign sec_edge = bus.esdi_sector & ~sector_q;

`ifdef ESDI_READ_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Held at zero outside WAIT_SECTOR so every entry starts a fresh count.
  always_ff @(posedge sector_aclk or posedge sector_areset) begin
    if (sector_areset) begin
      tmo_cnt <= '0;
    end else if (state != S_WAIT_SECTOR) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TMO_LAST) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  logic unused_timeout_param;
  assign unused_timeout_param = (TIMEOUT_CYCLES != 0);
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge sector_aclk or posedge sector_areset) begin
    if (sector_areset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      cap_delay    <= '0;
      cap_hdr_len  <= '0;
      cap_gap_len  <= '0;
      cap_data_len <= '0;
      sector_q     <= 1'b0;
      edge_pend    <= 1'b0;
      cmd_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      hdr_r        <= 1'b0;
      data_r       <= 1'b0;
      gate_r       <= 1'b0;
      remaining_r  <= '0;
    end else begin
      sector_q <= bus.esdi_sector;
      done_r   <= 1'b0;
      // Abort outranks everything, including a simultaneous overrun.
      if (bus.abort && (state != S_IDLE)) begin
        state       <= S_IDLE;
        cmd_ready_r <= 1'b1;
        busy_r      <= 1'b0;
        hdr_r       <= 1'b0;
        data_r      <= 1'b0;
        gate_r      <= 1'b0;
        edge_pend   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.cmd_valid) begin
              cap_delay    <= bus.cfg_header_delay;
              cap_hdr_len  <= (bus.cfg_header_len == '0) ? CNT_ONE : bus.cfg_header_len;
              cap_gap_len  <= bus.cfg_gap_len;
              cap_data_len <= (bus.cfg_data_len == '0) ? CNT_ONE : bus.cfg_data_len;
              remaining_r  <= {(bus.cmd_sector_count == 8'd0), bus.cmd_sector_count};
              error_r      <= 1'b0;
              edge_pend    <= 1'b0;
              cmd_ready_r  <= 1'b0;
              busy_r       <= 1'b1;
              state        <= S_WAIT_SECTOR;
            end
          end
          S_WAIT_SECTOR: begin
            if (sec_edge || edge_pend) begin
              edge_pend <= 1'b0;
              if (cap_delay == '0) begin
                state  <= S_HDR_GATE;
                cnt    <= cap_hdr_len;
                gate_r <= 1'b1;
                hdr_r  <= 1'b1;
              end else begin
                state <= S_HDR_DELAY;
                cnt   <= cap_delay;
              end
            end else if (tmo_hit) begin
              state       <= S_IDLE;
              error_r     <= 1'b1;
              cmd_ready_r <= 1'b1;
              busy_r      <= 1'b0;
            end
          end
          // Timed windows share one down-counter; a sector edge here means overrun.
          S_HDR_DELAY, S_HDR_GATE, S_GAP, S_DATA_GATE: begin
            if (sec_edge) begin
              state       <= S_IDLE;
              error_r     <= 1'b1;
              cmd_ready_r <= 1'b1;
              busy_r      <= 1'b0;
              hdr_r       <= 1'b0;
              data_r      <= 1'b0;
              gate_r      <= 1'b0;
            end else if (cnt != CNT_ONE) begin
              cnt <= cnt - CNT_ONE;
            end else if (state == S_DATA_GATE) begin
              state  <= S_NEXT;
              data_r <= 1'b0;
              gate_r <= 1'b0;
            end else if (state == S_HDR_DELAY) begin
              state  <= S_HDR_GATE;
              cnt    <= cap_hdr_len;
              gate_r <= 1'b1;
              hdr_r  <= 1'b1;
            end else if ((state == S_GAP) || (cap_gap_len == '0)) begin
              state  <= S_DATA_GATE;
              cnt    <= cap_data_len;
              gate_r <= 1'b1;
              hdr_r  <= 1'b0;
              data_r <= 1'b1;
            end else begin
              state  <= S_GAP;
              cnt    <= cap_gap_len;
              gate_r <= 1'b0;
              hdr_r  <= 1'b0;
            end
          end
          S_NEXT: begin
            remaining_r <= remaining_r - 9'd1;
            if (remaining_r == 9'd1) begin
              state       <= S_IDLE;
              done_r      <= 1'b1;
              cmd_ready_r <= 1'b1;
              busy_r      <= 1'b0;
            end else begin
              state     <= S_WAIT_SECTOR;
              edge_pend <= sec_edge;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.cmd_ready         = cmd_ready_r;
  assign bus.busy              = busy_r;
  assign bus.done              = done_r;
  assign bus.error             = error_r;
  assign bus.esdi_read_gate    = gate_r;
  assign bus.gate_for_header   = hdr_r;
  assign bus.gate_for_data     = data_r;
  assign bus.sectors_remaining = remaining_r;
endmodule

// File: tb/tb_esdi_read_sequencer.sv
// Directed bench for esdi_read_sequencer; timeout checks follow ESDI_READ_SEQ_TIMEOUT_EN.
module tb_esdi_read_sequencer;
  localparam int unsigned CW = 16;
`ifdef ESDI_READ_SEQ_TIMEOUT_EN
  localparam int unsigned TMO = 50;
`else
  localparam int unsigned TMO = 1000000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  esdi_read_sequencer_if #(.CNT_WIDTH(CW)) bus ();

  esdi_read_sequencer #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(TMO)) dut (
    .sector_aclk   (clk),
    .sector_areset (rst),
    .bus           (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // {read_gate, gate_for_header, gate_for_data, done}
  function automatic logic [3:0] obs();
    return {bus.esdi_read_gate, bus.gate_for_header, bus.gate_for_data, bus.done};
  endfunction

  // {busy, cmd_ready, error}
  function automatic logic [2:0] stat();
    return {bus.busy, bus.cmd_ready, bus.error};
  endfunction

  task automatic start_cmd(input logic [7:0] count, input int d, input int h, input int g,
                           input int l, input logic [8:0] exp_rem);
    bus.cfg_header_delay = CW'(d);
    bus.cfg_header_len   = CW'(h);
    bus.cfg_gap_len      = CW'(g);
    bus.cfg_data_len     = CW'(l);
    bus.cmd_sector_count = count;
    bus.cmd_valid        = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    check("accept_stat", 32'(stat()), 32'(3'b100));
    check("accept_rem", 32'(bus.sectors_remaining), 32'(exp_rem));
    // Later config changes must not affect the running command.
    bus.cfg_header_delay = CW'(7);
    bus.cfg_header_len   = CW'(9);
    bus.cfg_gap_len      = CW'(5);
    bus.cfg_data_len     = CW'(11);
  endtask

  // One sector: optional pulse at cycle t, then gate trace checked from t+1 to t+NEXT+1.
  task automatic sector_seq(input string tag, input int d, input int h, input int g, input int l,
                            input bit pulse, input bit next_edge, input bit last,
                            input logic [8:0] exp_rem);
    int he, le, hs, hend, ds, de, nx;
    logic hd, dt, dn;
    he   = (h == 0) ? 1 : h;
    le   = (l == 0) ? 1 : l;
    hs   = 1 + d;
    hend = d + he;
    ds   = hend + g + 1;
    de   = ds + le - 1;
    nx   = de + 1;
    bus.esdi_sector = pulse;
    tick();
    bus.esdi_sector = 1'b0;
    for (int k = 1; k <= nx + 1; k++) begin
      hd = (k >= hs) && (k <= hend);
      dt = (k >= ds) && (k <= de);
      dn = last && (k == nx + 1);
      check($sformatf("%s_k%0d", tag, k), 32'(obs()), 32'({hd | dt, hd, dt, dn}));
      if (k == nx + 1) break;
      bus.esdi_sector = next_edge && (k == nx);
      tick();
      bus.esdi_sector = 1'b0;
    end
    check({tag, "_busy"}, 32'(bus.busy), 32'(!last));
    check({tag, "_rem"}, 32'(bus.sectors_remaining), 32'(exp_rem));
  endtask

  initial begin
    bus.cmd_valid        = 1'b0;
    bus.cmd_sector_count = 8'd0;
    bus.cfg_header_delay = '0;
    bus.cfg_header_len   = '0;
    bus.cfg_gap_len      = '0;
    bus.cfg_data_len     = '0;
    bus.esdi_sector      = 1'b0;
    bus.abort            = 1'b0;

    tickn(3);
    check("rst_obs", 32'(obs()), 32'd0);
    check("rst_stat", 32'(stat()), 32'(3'b010));
    check("rst_rem", 32'(bus.sectors_remaining), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_stat", 32'(stat()), 32'(3'b010));

    // Single sector, D=3 H=4 G=2 L=8
    start_cmd(8'd1, 3, 4, 2, 8, 9'd1);
    tickn(5);
    sector_seq("one", 3, 4, 2, 8, 1'b1, 1'b0, 1'b1, 9'd0);
    check("one_err", 32'(bus.error), 32'd0);
    tick();
    check("one_done_pulse", 32'(obs()), 32'd0);

    // Three sectors, pulses about 100 cycles apart
    start_cmd(8'd3, 3, 4, 2, 8, 9'd3);
    for (int i = 0; i < 3; i++) begin
      tickn(80);
      sector_seq($sformatf("three%0d", i), 3, 4, 2, 8, 1'b1, 1'b0, i == 2, 9'(2 - i));
    end
    check("three_err", 32'(bus.error), 32'd0);

    // Overrun during data window
    start_cmd(8'd2, 3, 4, 2, 8, 9'd2);
    tickn(2);
    bus.esdi_sector = 1'b1;
    tick();
    bus.esdi_sector = 1'b0;
    tickn(11);
    check("ovr_in_data", 32'(obs()), 32'(4'b1010));
    bus.esdi_sector = 1'b1;
    tick();
    bus.esdi_sector = 1'b0;
    check("ovr_obs", 32'(obs()), 32'd0);
    check("ovr_stat", 32'(stat()), 32'(3'b011));
    check("ovr_rem", 32'(bus.sectors_remaining), 32'd2);
    tick();
    check("ovr_no_done", 32'(obs()), 32'd0);
    check("ovr_sticky", 32'(bus.error), 32'd1);

    // Next accept clears error; abort during gap
    start_cmd(8'd2, 3, 4, 2, 8, 9'd2);
    tickn(2);
    bus.esdi_sector = 1'b1;
    tick();
    bus.esdi_sector = 1'b0;
    tickn(7);
    check("gap_obs", 32'(obs()), 32'd0);
    check("gap_busy", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_obs", 32'(obs()), 32'd0);
    check("abort_stat", 32'(stat()), 32'(3'b010));
    tick();
    check("abort_no_done", 32'(obs()), 32'd0);

    // Abort and overrun together during header
    start_cmd(8'd1, 3, 4, 2, 8, 9'd1);
    tickn(2);
    bus.esdi_sector = 1'b1;
    tick();
    bus.esdi_sector = 1'b0;
    tickn(4);
    check("ab_ovr_hdr", 32'(obs()), 32'(4'b1100));
    bus.abort       = 1'b1;
    bus.esdi_sector = 1'b1;
    tick();
    bus.abort       = 1'b0;
    bus.esdi_sector = 1'b0;
    check("ab_ovr_obs", 32'(obs()), 32'd0);
    check("ab_ovr_stat", 32'(stat()), 32'(3'b010));

    // All zero lengths
    start_cmd(8'd1, 0, 0, 0, 0, 9'd1);
    tickn(2);
    sector_seq("zero", 0, 0, 0, 0, 1'b1, 1'b0, 1'b1, 9'd0);

    // Sector edge landing in NEXT starts the following sector
    start_cmd(8'd2, 0, 0, 0, 0, 9'd2);
    tickn(2);
    sector_seq("nxa", 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, 9'd1);
    sector_seq("nxb", 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 9'd0);

    // Count 0 means 256 sectors
    start_cmd(8'd0, 0, 0, 0, 0, 9'd256);
    for (int i = 0; i < 256; i++) begin
      tick();
      sector_seq("s256", 0, 0, 0, 0, 1'b1, 1'b0, i == 255, 9'(255 - i));
    end
    check("s256_err", 32'(bus.error), 32'd0);

    // Asynchronous reset mid-header
    start_cmd(8'd1, 3, 4, 2, 8, 9'd1);
    tickn(2);
    bus.esdi_sector = 1'b1;
    tick();
    bus.esdi_sector = 1'b0;
    tickn(4);
    check("arst_hdr", 32'(obs()), 32'(4'b1100));
    #2 rst = 1'b1;
    #1;
    check("arst_obs", 32'(obs()), 32'd0);
    check("arst_stat", 32'(stat()), 32'(3'b010));
    rst = 1'b0;
    tick();
    check("arst_idle", 32'(stat()), 32'(3'b010));

`ifdef ESDI_READ_SEQ_TIMEOUT_EN
    start_cmd(8'd1, 3, 4, 2, 8, 9'd1);
    tickn(49);
    check("tmo_still_busy", 32'(bus.busy), 32'd1);
    tick();
    check("tmo_stat", 32'(stat()), 32'(3'b011));
    check("tmo_no_done", 32'(obs()), 32'd0);
`else
    start_cmd(8'd1, 3, 4, 2, 8, 9'd1);
    tickn(10000);
    check("notmo_busy", 32'(stat()), 32'(3'b100));
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("notmo_abort", 32'(stat()), 32'(3'b010));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
